// File: rtl/bus_master_pkg.sv
// Shared op codes, FSM state encoding and widths for the bus master engine.
package bus_master_pkg;

  localparam int unsigned LenW = 8;

  typedef enum logic [1:0] {
    OpRead      = 2'd0,
    OpWrite     = 2'd1,
    OpBurstRead = 2'd2,
    OpRmw       = 2'd3
  } bm_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StBrd,
    StRmwRd,
    StRmwWr,
    StDrain
  } bm_state_e;

endpackage

// File: rtl/bus_master_fifo.sv
// Response FIFO: synchronous reset, head word visible combinationally, push ignored when full.
module bus_master_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 17
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (count_q != CntFull);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/bus_master_engine.sv
// Command-driven bus master (single, burst-read and read-modify-write) with response FIFO.
// Optional sticky slave interrupt flag enabled by defining BUS_MASTER_IRQ_EN.
module bus_master_engine
  import bus_master_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LenW-1:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              slave_read,
  output logic              slave_write,
  output logic [ADDR_W-1:0] slave_address,
  input  logic [DATA_W-1:0] slave_readdata,
  output logic [DATA_W-1:0] slave_writedata,
  output logic              slave_chipselect,
  input  logic              slave_waitrequest,
  output logic              slave_beginbursttransfer,
  output logic [LenW-1:0]   slave_burstcount,
  input  logic              slave_irq,
  output logic              irq_pending,
  input  logic              irq_ack
);

  localparam int unsigned     Depth    = BURST_MAX + 1;
  localparam int unsigned     WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [LenW-1:0]  BurstMax = LenW'(BURST_MAX);

  bm_state_e         state_q;
  logic [LenW-1:0]   beats_left_q;
  logic [WaitW-1:0]  wait_cnt_q;
  logic [DATA_W-1:0] wdata_q, mask_q;

  bm_op_e            op;
  logic              accept, bad_len, req_active, beat_done, timed_out;
  logic              push, pop, fifo_empty;
  logic [DATA_W:0]   push_word, head_word;

  assign op         = bm_op_e'(cmd_op);
  assign cmd_ready  = (state_q == StIdle) && fifo_empty && !Reset;
  assign accept     = cmd_valid && cmd_ready;
  assign bad_len    = (cmd_len == '0) || (cmd_len > BurstMax);
  assign req_active = slave_read || slave_write;
  assign beat_done  = req_active && !slave_waitrequest;
  assign timed_out  = req_active && slave_waitrequest && (wait_cnt_q == WaitLast);

  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_empty ? '0 : head_word[DATA_W-1:0];
  assign rsp_err   = !fifo_empty && head_word[DATA_W];

  // Response word layout: {err, data}.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (accept && (op == OpBurstRead) && bad_len) begin
      push      = 1'b1;
      push_word = {1'b1, {DATA_W{1'b0}}};
    end else if (timed_out) begin
      push      = 1'b1;
      push_word = {1'b1, {DATA_W{1'b0}}};
    end else if (beat_done) begin
      unique case (state_q)
        StRd, StBrd, StRmwRd: begin
          push      = 1'b1;
          push_word = {1'b0, slave_readdata};
        end
        StWr:    push = 1'b1;
        default: ;
      endcase
    end
  end

  bus_master_fifo #(
    .Width(DATA_W + 1),
    .Depth(Depth)
  ) u_fifo (
    .Clk        (Clk),
    .Reset      (Reset),
    .push_i     (push),
    .push_data_i(push_word),
    .pop_i      (pop),
    .head_o     (head_word),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q                  <= StIdle;
      beats_left_q             <= '0;
      wait_cnt_q               <= '0;
      wdata_q                  <= '0;
      mask_q                   <= '0;
      slave_read               <= 1'b0;
      slave_write              <= 1'b0;
      slave_chipselect         <= 1'b0;
      slave_address            <= '0;
      slave_writedata          <= '0;
      slave_beginbursttransfer <= 1'b0;
      slave_burstcount         <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            wdata_q    <= cmd_wdata;
            mask_q     <= cmd_mask;
            wait_cnt_q <= '0;
            unique case (op)
              OpRead: begin
                slave_read       <= 1'b1;
                slave_chipselect <= 1'b1;
                slave_address    <= cmd_addr;
                slave_burstcount <= LenW'(1);
                state_q          <= StRd;
              end
              OpWrite: begin
                slave_write      <= 1'b1;
                slave_chipselect <= 1'b1;
                slave_address    <= cmd_addr;
                slave_writedata  <= cmd_wdata;
                slave_burstcount <= LenW'(1);
                state_q          <= StWr;
              end
              OpBurstRead: begin
                if (bad_len) begin
                  state_q <= StDrain;
                end else begin
                  slave_read               <= 1'b1;
                  slave_chipselect         <= 1'b1;
                  slave_address            <= cmd_addr;
                  slave_beginbursttransfer <= 1'b1;
                  slave_burstcount         <= cmd_len;
                  beats_left_q             <= cmd_len;
                  state_q                  <= StBrd;
                end
              end
              OpRmw: begin
                slave_read       <= 1'b1;
                slave_chipselect <= 1'b1;
                slave_address    <= cmd_addr;
                slave_burstcount <= LenW'(1);
                state_q          <= StRmwRd;
              end
            endcase
          end
        end
        StRd, StWr, StBrd, StRmwRd, StRmwWr: begin
          slave_beginbursttransfer <= 1'b0;
          if (timed_out) begin
            slave_read       <= 1'b0;
            slave_write      <= 1'b0;
            slave_chipselect <= 1'b0;
            slave_address    <= '0;
            slave_writedata  <= '0;
            slave_burstcount <= '0;
            state_q          <= StDrain;
          end else if (beat_done) begin
            wait_cnt_q <= '0;
            if (state_q == StRmwRd) begin
              // Write phase follows immediately at the same address.
              slave_read      <= 1'b0;
              slave_write     <= 1'b1;
              slave_writedata <= (slave_readdata & ~mask_q) | (wdata_q & mask_q);
              state_q         <= StRmwWr;
            end else if ((state_q == StBrd) && (beats_left_q != LenW'(1))) begin
              beats_left_q <= beats_left_q - LenW'(1);
            end else begin
              slave_read       <= 1'b0;
              slave_write      <= 1'b0;
              slave_chipselect <= 1'b0;
              slave_address    <= '0;
              slave_writedata  <= '0;
              slave_burstcount <= '0;
              state_q          <= StDrain;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StDrain: begin
          if (fifo_empty) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef BUS_MASTER_IRQ_EN
  logic irq_prev_q;

  // A new rising edge wins over a same-cycle acknowledge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      irq_prev_q  <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_prev_q <= slave_irq;
      if (slave_irq && !irq_prev_q) begin
        irq_pending <= 1'b1;
      end else if (irq_ack) begin
        irq_pending <= 1'b0;
      end
    end
  end
`else
  logic unused_irq;
  assign unused_irq  = slave_irq ^ irq_ack;
  assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_engine.sv
// Directed self-checking bench for bus_master_engine with a scripted slave (TIMEOUT = 8).
module tb_bus_master_engine;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

`ifdef BUS_MASTER_IRQ_EN
  localparam logic IrqExp = 1'b1;
`else
  localparam logic IrqExp = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          slave_read, slave_write, slave_chipselect, slave_beginbursttransfer;
  logic [AW-1:0] slave_address;
  logic [DW-1:0] slave_readdata = '0;
  logic [DW-1:0] slave_writedata;
  logic          slave_waitrequest = 1'b0;
  logic [7:0]    slave_burstcount;
  logic          slave_irq = 1'b0;
  logic          irq_pending;
  logic          irq_ack = 1'b0;

  always #5 Clk = ~Clk;

  bus_master_engine #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .BURST_MAX(16),
    .TIMEOUT  (8)
  ) dut (
    .Clk                     (Clk),
    .Reset                   (Reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_op                  (cmd_op),
    .cmd_addr                (cmd_addr),
    .cmd_len                 (cmd_len),
    .cmd_wdata               (cmd_wdata),
    .cmd_mask                (cmd_mask),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_data                (rsp_data),
    .rsp_err                 (rsp_err),
    .slave_read              (slave_read),
    .slave_write             (slave_write),
    .slave_address           (slave_address),
    .slave_readdata          (slave_readdata),
    .slave_writedata         (slave_writedata),
    .slave_chipselect        (slave_chipselect),
    .slave_waitrequest       (slave_waitrequest),
    .slave_beginbursttransfer(slave_beginbursttransfer),
    .slave_burstcount        (slave_burstcount),
    .slave_irq               (slave_irq),
    .irq_pending             (irq_pending),
    .irq_ack                 (irq_ack)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Results gathered by run_slave.
  int            s_reqs, s_begins, s_beats;
  logic [7:0]    s_bc_first;
  logic          s_bc_stable, s_cs_bad;
  logic [DW-1:0] s_wdata;
  logic [AW-1:0] s_addr;

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] mask);
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge Clk);
    check("cmd_ready_before_cmd", 64'(cmd_ready), 64'(1));
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_wdata = wdata;
    cmd_mask  = mask;
    cmd_valid = 1'b1;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Each beat is stalled for `waits` cycles; beat n returns base+n. stop_after>0 asserts Reset
  // in the request cycle after that many beats completed.
  task automatic run_slave(input int waits, input logic [DW-1:0] base, input int stop_after,
                           input int max_cycles);
    int wib;
    wib = 0;
    s_reqs = 0; s_begins = 0; s_beats = 0; s_bc_first = '0; s_bc_stable = 1'b1;
    s_cs_bad = 1'b0; s_wdata = '0; s_addr = '0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge Clk);
      if (slave_chipselect != (slave_read || slave_write)) s_cs_bad = 1'b1;
      if (slave_read || slave_write) begin
        if (stop_after > 0 && s_beats == stop_after) begin
          Reset = 1'b1;
          break;
        end
        s_reqs++;
        if (slave_beginbursttransfer) s_begins++;
        if (s_reqs == 1) s_bc_first = slave_burstcount;
        else if (slave_burstcount != s_bc_first) s_bc_stable = 1'b0;
        if (slave_write) begin
          s_wdata = slave_writedata;
          s_addr  = slave_address;
        end
        if (wib < waits) begin
          slave_waitrequest = 1'b1;
          wib++;
        end else begin
          slave_waitrequest = 1'b0;
          slave_readdata    = base + DW'(s_beats);
          s_beats++;
          wib = 0;
        end
      end else begin
        slave_waitrequest = 1'b0;
        if (s_reqs > 0) break;
      end
    end
    slave_waitrequest = 1'b0;
  endtask

  task automatic pop_rsp(input string tag, input logic [DW-1:0] exp_data, input logic exp_err);
    for (int c = 0; c < 50; c++) begin
      @(negedge Clk);
      if (rsp_valid) break;
    end
    check({tag, "_valid"}, 64'(rsp_valid), 64'(1));
    check({tag, "_data"}, 64'(rsp_data), 64'(exp_data));
    check({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_bus_req", 64'({slave_read, slave_write, slave_chipselect}), 64'(0));
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'(1));

    // WRITE with two stall cycles.
    send_cmd(2'd1, 3'd3, 8'd0, 32'h00AABBCC, 32'h0);
    run_slave(2, 32'h0, 0, 40);
    check("wr_req_cycles", 64'(s_reqs), 64'(3));
    check("wr_chipselect", 64'(s_cs_bad), 64'(0));
    check("wr_addr", 64'(s_addr), 64'(3));
    check("wr_data", 64'(s_wdata), 64'h00AABBCC);
    check("wr_burstcount", 64'(s_bc_first), 64'(1));
    pop_rsp("wr_rsp", 32'h0, 1'b0);
    @(negedge Clk);
    check("wr_rsp_empty", 64'(rsp_valid), 64'(0));

    // BURST_READ of 4 with responses held back.
    send_cmd(2'd2, 3'd1, 8'd4, 32'h0, 32'h0);
    run_slave(0, 32'd1, 0, 40);
    check("brd_req_cycles", 64'(s_reqs), 64'(4));
    check("brd_begin_cycles", 64'(s_begins), 64'(1));
    check("brd_burstcount", 64'(s_bc_first), 64'(4));
    check("brd_burstcount_stable", 64'(s_bc_stable), 64'(1));
    repeat (3) @(negedge Clk);
    check("brd_cmd_ready_held", 64'(cmd_ready), 64'(0));
    for (int i = 0; i < 3; i++) pop_rsp("brd_rsp", DW'(i + 1), 1'b0);
    @(negedge Clk);
    check("brd_cmd_ready_partial", 64'(cmd_ready), 64'(0));
    pop_rsp("brd_rsp_last", 32'd4, 1'b0);

    // RMW: merge insert data under mask, respond with the original word.
    send_cmd(2'd3, 3'd5, 8'd0, 32'h00ABCDEF, 32'h00FFFFFF);
    run_slave(1, 32'h12345678, 0, 40);
    check("rmw_req_cycles", 64'(s_reqs), 64'(4));
    check("rmw_wdata", 64'(s_wdata), 64'h12ABCDEF);
    check("rmw_addr", 64'(s_addr), 64'(5));
    pop_rsp("rmw_rsp", 32'h12345678, 1'b0);
    @(negedge Clk);
    check("rmw_rsp_single", 64'(rsp_valid), 64'(0));

    // READ stuck in waitrequest times out after 8 cycles.
    send_cmd(2'd0, 3'd6, 8'd0, 32'h0, 32'h0);
    run_slave(1000, 32'hDEAD0000, 0, 40);
    check("to_req_cycles", 64'(s_reqs), 64'(8));
    pop_rsp("to_rsp", 32'h0, 1'b1);

    // Completing on exactly the eighth request cycle is still good.
    send_cmd(2'd0, 3'd6, 8'd0, 32'h0, 32'h0);
    run_slave(7, 32'h0BADF00D, 0, 40);
    check("edge_req_cycles", 64'(s_reqs), 64'(8));
    pop_rsp("edge_rsp", 32'h0BADF00D, 1'b0);

    // Illegal burst lengths: no bus cycle, one error word.
    send_cmd(2'd2, 3'd0, 8'd0, 32'h0, 32'h0);
    run_slave(0, 32'h0, 0, 10);
    check("len0_req_cycles", 64'(s_reqs), 64'(0));
    pop_rsp("len0_rsp", 32'h0, 1'b1);
    send_cmd(2'd2, 3'd0, 8'd17, 32'h0, 32'h0);
    run_slave(0, 32'h0, 0, 10);
    check("len17_req_cycles", 64'(s_reqs), 64'(0));
    pop_rsp("len17_rsp", 32'h0, 1'b1);

    // Reset in the middle of a len-8 burst.
    send_cmd(2'd2, 3'd4, 8'd8, 32'h0, 32'h0);
    run_slave(0, 32'h100, 2, 40);
    check("mid_beats", 64'(s_beats), 64'(2));
    check("mid_rsp_valid", 64'(rsp_valid), 64'(1));
    @(negedge Clk);
    check("mrst_req", 64'({slave_read, slave_write, slave_chipselect}), 64'(0));
    check("mrst_begin", 64'(slave_beginbursttransfer), 64'(0));
    check("mrst_burstcount", 64'(slave_burstcount), 64'(0));
    check("mrst_addr", 64'(slave_address), 64'(0));
    check("mrst_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'(0));
    check("mrst_cmd_ready", 64'(cmd_ready), 64'(0));
    Reset = 1'b0;
    @(negedge Clk);
    check("mrst_cmd_ready_after", 64'(cmd_ready), 64'(1));
    send_cmd(2'd0, 3'd2, 8'd0, 32'h0, 32'h0);
    run_slave(0, 32'hCAFE0001, 0, 40);
    check("post_rst_req_cycles", 64'(s_reqs), 64'(1));
    pop_rsp("post_rst_rsp", 32'hCAFE0001, 1'b0);

    // Interrupt flag.
    @(negedge Clk);
    slave_irq = 1'b1;
    @(negedge Clk);
    check("irq_set", 64'(irq_pending), 64'(IrqExp));
    irq_ack = 1'b1;
    @(negedge Clk);
    check("irq_ack", 64'(irq_pending), 64'(0));
    irq_ack   = 1'b0;
    slave_irq = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
